// File: rtl/dpu_fram_master_if.sv
// Bus between the fram master and a fram: registered strobes and address/write data out,
// read value and attribute back.
interface dpu_fram_master_if #(
    parameter int W  = 32,
    parameter int WA = 4,
    parameter int AW = 4
);
    logic [AW-1:0] dp_addr;
    logic          dp_wr;
    logic [W-1:0]  dp_data;
    logic [WA-1:0] dp_attr_i;
    logic          dp_oe;
    logic [W-1:0]  dp_value;
    logic [WA-1:0] dp_attr_o;

    modport master (
        output dp_addr, dp_wr, dp_data, dp_attr_i, dp_oe,
        input  dp_value, dp_attr_o
    );

    modport slave (
        input  dp_addr, dp_wr, dp_data, dp_attr_i, dp_oe,
        output dp_value, dp_attr_o
    );
endinterface

// File: rtl/dpu_fram_master.sv
// Program-driven fram initiator: runs READ/WRITE/LOAD/HALT steps from a small program memory,
// moving words between fram cells through one transfer register.
module dpu_fram_master #(
    parameter int W          = 32,
    parameter int WA         = 4,
    parameter int AW         = 4,
    parameter int PROG_DEPTH = 16,
    parameter int RD_LAT     = 1,
    localparam int PCW       = $clog2(PROG_DEPTH)
) (
    input  logic            dp_clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [PCW-1:0]  prog_addr,
    input  logic [3+AW-1:0] prog_data,
    input  logic            start,
    input  logic [W-1:0]    ext_data,
    input  logic [WA-1:0]   ext_attr,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [W-1:0]    xfer_value,
    output logic [WA-1:0]   xfer_attr,
    dpu_fram_master_if.master dp
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_e;

    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_HALT  = 3'b100;

    logic [3+AW-1:0] prog_mem [PROG_DEPTH];

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            last_q, last_d;   // the READ being waited on was the final program slot
    logic            wcnt_q, wcnt_d;
    logic            err_q, err_d;
    logic [W-1:0]    xv_q, xv_d;
    logic [WA-1:0]   xa_q, xa_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_q, wr_d;
    logic            oe_q, oe_d;
    logic [W-1:0]    data_q, data_d;
    logic [WA-1:0]   attr_q, attr_d;

    logic [3+AW-1:0] instr;
    logic [2:0]      op;
    logic [AW-1:0]   op_addr;

    assign instr   = prog_mem[pc_q];
    assign op      = instr[3+AW-1 -: 3];
    assign op_addr = instr[AW-1:0];

    // Program memory survives reset; writes only land while idle.
    always_ff @(posedge dp_clk) begin
        if (rst_n && prog_we && state_q == S_IDLE)
            prog_mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge dp_clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            last_q  <= 1'b0;
            wcnt_q  <= 1'b0;
            err_q   <= 1'b0;
            xv_q    <= '0;
            xa_q    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            oe_q    <= 1'b0;
            data_q  <= '0;
            attr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            xv_q    <= xv_d;
            xa_q    <= xa_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            attr_q  <= attr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        xv_d    = xv_q;
        xa_d    = xa_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        oe_d    = 1'b0;
        data_d  = data_q;
        attr_d  = attr_q;

        if ((state_q == S_RUN || state_q == S_WAIT) && (start || prog_we))
            err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                pc_d   = pc_q + 1'b1;
                last_d = (pc_q == PCW'(PROG_DEPTH - 1));
                case (op)
                    OP_READ: begin
                        oe_d    = 1'b1;
                        addr_d  = op_addr;
                        wcnt_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                    OP_WRITE: begin
                        wr_d   = 1'b1;
                        addr_d = op_addr;
                        data_d = xv_q;
                        attr_d = xa_q;
                    end
                    OP_LOAD: begin
                        xv_d = ext_data;
                        xa_d = ext_attr;
                    end
                    OP_HALT: state_d = S_DONE;
                    default: ;
                endcase
                // No wrap: the last slot ends the program unless it still has a read in flight.
                if (op != OP_READ && pc_q == PCW'(PROG_DEPTH - 1))
                    state_d = S_DONE;
            end
            S_WAIT: begin
                if (wcnt_q == 1'(RD_LAT)) begin
                    xv_d    = dp.dp_value;
                    xa_d    = dp.dp_attr_o;
                    state_d = last_q ? S_DONE : S_RUN;
                end else begin
                    wcnt_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q == S_RUN) || (state_q == S_WAIT);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign xfer_value    = xv_q;
    assign xfer_attr     = xa_q;
    assign dp.dp_addr    = addr_q;
    assign dp.dp_wr      = wr_q;
    assign dp.dp_oe      = oe_q;
    assign dp.dp_data    = data_q;
    assign dp.dp_attr_i  = attr_q;
endmodule

// File: tb/tb_dpu_fram_master.sv
// Drives an RD_LAT=0 and an RD_LAT=1 build side by side, each with its own fram model, and checks
// both against a program-level reference of fram contents, transfer register and cycle counts.
module tb_dpu_fram_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [6:0] prog_data = '0;
    logic start = 1'b0;
    logic [31:0] ext_data = '0;
    logic [3:0] ext_attr = '0;

    logic bk_we = 1'b0;
    logic [3:0] bk_addr = '0;
    logic [31:0] bk_v = '0;
    logic [3:0] bk_a = '0;

    logic [1:0] busy_s, done_s, err_s, wr_s, oe_s;
    logic [1:0][31:0] xv_s, data_s;
    logic [1:0][3:0] xa_s, attr_s, addr_s;
    logic [1:0][15:0][31:0] fram_v;
    logic [1:0][15:0][3:0] fram_a;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g
        dpu_fram_master_if #(.W(32), .WA(4), .AW(4)) bus ();
        logic [15:0][31:0] mv;
        logic [15:0][3:0] ma;

        dpu_fram_master #(.W(32), .WA(4), .AW(4), .PROG_DEPTH(16), .RD_LAT(k)) dut (
            .dp_clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
            .prog_data(prog_data), .start(start), .ext_data(ext_data), .ext_attr(ext_attr),
            .busy(busy_s[k]), .done(done_s[k]), .err(err_s[k]),
            .xfer_value(xv_s[k]), .xfer_attr(xa_s[k]), .dp(bus)
        );

        always @(posedge clk) begin
            if (bk_we) begin
                mv[bk_addr] <= bk_v;
                ma[bk_addr] <= bk_a;
            end else if (bus.dp_wr) begin
                mv[bus.dp_addr] <= bus.dp_data;
                ma[bus.dp_addr] <= bus.dp_attr_i;
            end
        end

        if (k == 0) begin : g_lat0
            assign bus.dp_value  = mv[bus.dp_addr];
            assign bus.dp_attr_o = ma[bus.dp_addr];
        end else begin : g_lat1
            logic [31:0] rv_q;
            logic [3:0] ra_q;
            always @(posedge clk) if (bus.dp_oe) begin
                rv_q <= mv[bus.dp_addr];
                ra_q <= ma[bus.dp_addr];
            end
            assign bus.dp_value  = rv_q;
            assign bus.dp_attr_o = ra_q;
        end

        assign wr_s[k]   = bus.dp_wr;
        assign oe_s[k]   = bus.dp_oe;
        assign addr_s[k] = bus.dp_addr;
        assign data_s[k] = bus.dp_data;
        assign attr_s[k] = bus.dp_attr_i;
        assign fram_v[k] = mv;
        assign fram_a[k] = ma;
    end

    // Reference state: fram contents and transfer register as the program semantics dictate.
    logic [31:0] ref_v [16];
    logic [3:0]  ref_a [16];
    logic [31:0] ref_xv = '0;
    logic [3:0]  ref_xa = '0;
    logic [6:0]  prog [16];
    int exp_cyc [2];
    int exp_wr, exp_oe;
    int bc [2], dc [2], dn [2], wc [2], oc [2], both [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ins(input logic [2:0] op, input logic [3:0] a);
        return {op, a};
    endfunction

    task automatic bk_write(input int a, input logic [31:0] v, input logic [3:0] at);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = 4'(a); bk_v = v; bk_a = at;
        ref_v[a] = v; ref_a[a] = at;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic preload_random();
        for (int a = 0; a < 16; a++) bk_write(a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Each step costs one cycle except READ, which costs two plus the read latency.
    task automatic model();
        int reads = 0, others = 0;
        exp_wr = 0; exp_oe = 0;
        for (int p = 0; p < 16; p++) begin
            logic [2:0] op;
            logic [3:0] a;
            op = prog[p][6:4];
            a  = prog[p][3:0];
            if (op == 3'd1) begin
                ref_xv = ref_v[a]; ref_xa = ref_a[a]; reads++; exp_oe++;
            end else begin
                others++;
                if (op == 3'd2) begin ref_v[a] = ref_xv; ref_a[a] = ref_xa; exp_wr++; end
                if (op == 3'd3) begin ref_xv = ext_data; ref_xa = ext_attr; end
                if (op == 3'd4) break;
            end
        end
        for (int k = 0; k < 2; k++) exp_cyc[k] = others + reads * (2 + k);
    endtask

    task automatic run_prog(input string tag, input bit inject, input bit exp_err);
        model();
        for (int k = 0; k < 2; k++) begin
            bc[k] = 0; dc[k] = 0; dn[k] = 0; wc[k] = 0; oc[k] = 0; both[k] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= exp_cyc[1] + 4; n++) begin
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            if (n == 1)
                for (int k = 0; k < 2; k++) check({tag, "_err_cleared"}, 64'(err_s[k]), 64'd0);
            if (inject && n == 2) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd4; prog_data = ins(3'd2, 4'd9);
            end
            for (int k = 0; k < 2; k++) begin
                if (busy_s[k]) bc[k]++;
                if (done_s[k]) begin dc[k]++; dn[k] = n; end
                if (wr_s[k]) wc[k]++;
                if (oe_s[k]) oc[k]++;
                if (wr_s[k] && oe_s[k]) both[k]++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            check({tag, "_done_count"}, 64'(dc[k]), 64'd1);
            check({tag, "_done_cycle"}, 64'(dn[k]), 64'(exp_cyc[k] + 1));
            check({tag, "_busy_cycles"}, 64'(bc[k]), 64'(exp_cyc[k]));
            check({tag, "_wr_pulses"}, 64'(wc[k]), 64'(exp_wr));
            check({tag, "_oe_pulses"}, 64'(oc[k]), 64'(exp_oe));
            check({tag, "_wr_oe_overlap"}, 64'(both[k]), 64'd0);
            check({tag, "_err"}, 64'(err_s[k]), 64'(exp_err));
            check({tag, "_xfer"}, {28'd0, xv_s[k], xa_s[k]}, {28'd0, ref_xv, ref_xa});
            for (int a = 0; a < 16; a++)
                check({tag, "_fram"}, {28'd0, fram_v[k][a], fram_a[k][a]}, {28'd0, ref_v[a], ref_a[a]});
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_flags"}, 64'({busy_s[k], done_s[k], err_s[k], wr_s[k], oe_s[k]}), 64'd0);
            check({tag, "_xfer"}, {28'd0, xv_s[k], xa_s[k]}, 64'd0);
            check({tag, "_bus"}, {24'd0, addr_s[k], data_s[k], attr_s[k]}, 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        preload_random();

        // Directed copy: fram[3] -> fram[7] through the transfer register.
        bk_write(3, 32'hA03, 4'd2);
        for (int i = 0; i < 16; i++) prog[i] = ins(3'd0, 4'd0);
        prog[0] = ins(3'd1, 4'd3); prog[1] = ins(3'd2, 4'd7); prog[2] = ins(3'd4, 4'd0);
        load_prog();
        run_prog("copy", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("copy_fram7", {28'd0, fram_v[k][7], fram_a[k][7]}, {28'd0, 32'hA03, 4'd2});
            check("copy_latency", 64'(dn[k]), 64'(5 + k));
        end

        // Abort mid-run with a held start (raises err first); reset must clear everything.
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("abort");
        ref_xv = '0; ref_xa = '0;
        dc[0] = 0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk) if (done_s[0] || done_s[1]) dc[0]++;
        check("abort_no_done", 64'(dc[0]), 64'd0);
        run_prog("retained", 1'b0, 1'b0);

        // LOAD, write it out, read it back.
        ext_data = 32'hDEADBEEF; ext_attr = 4'd5;
        for (int i = 0; i < 16; i++) prog[i] = ins(3'd0, 4'd0);
        prog[0] = ins(3'd3, 4'd0); prog[1] = ins(3'd2, 4'd15);
        prog[2] = ins(3'd1, 4'd15); prog[3] = ins(3'd4, 4'd0);
        load_prog();
        run_prog("load", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("load_xfer", {28'd0, xv_s[k], xa_s[k]}, {28'd0, 32'hDEADBEEF, 4'd5});
            check("load_strobes", 64'({wc[k], oc[k]}), 64'({32'd1, 32'd1}));
        end

        // Sixteen no-op slots (including the undefined opcodes): implicit halt, no wrap.
        for (int i = 0; i < 16; i++) prog[i] = ins((i % 4 == 0) ? 3'd0 : 3'(4 + (i % 4)), 4'(i));
        load_prog();
        run_prog("nops", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("nops_busy", 64'(bc[k]), 64'd16);
            check("nops_done", 64'(dn[k]), 64'd17);
        end

        // start/prog_we while busy are dropped and flag err; a later start clears it.
        for (int i = 0; i < 16; i++) prog[i] = ins(3'd0, 4'd0);
        prog[0] = ins(3'd1, 4'd3); prog[1] = ins(3'd2, 4'd7); prog[5] = ins(3'd4, 4'd0);
        load_prog();
        run_prog("busy_err", 1'b1, 1'b1);
        run_prog("err_clear", 1'b0, 1'b0);

        // READ i / WRITE i+8 chain filling every slot.
        preload_random();
        for (int i = 0; i < 8; i++) begin
            prog[2*i] = ins(3'd1, 4'(i)); prog[2*i+1] = ins(3'd2, 4'(i + 8));
        end
        load_prog();
        run_prog("chain", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 8; a++)
                check("chain_copy", {28'd0, fram_v[k][a+8], fram_a[k][a+8]},
                      {28'd0, fram_v[k][a], fram_a[k][a]});

        // Random programs and operands against the reference.
        for (int t = 0; t < 4; t++) begin
            preload_random();
            ext_data = $urandom; ext_attr = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) prog[i] = ins(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            load_prog();
            run_prog("random", 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
